// File: rtl/cluster_pkg.sv
// Shared constants, state encoding and helpers for the cluster PE sequencer.
package cluster_pkg;

  localparam int unsigned DIM         = 3;
  localparam int unsigned DATA_RANGE  = 255;
  localparam int unsigned MAX_DEPTH   = 16;
  localparam int unsigned DIM_SIZE    = $clog2(DATA_RANGE);
  localparam int unsigned CENTER_SIZE = DIM * DIM_SIZE;
  localparam int unsigned DEPTH_SIZE  = $clog2(MAX_DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SEED_RDY = 4'd1,
    ST_SEED     = 4'd2,
    ST_START    = 4'd3,
    ST_RDY      = 4'd4,
    ST_RECV     = 4'd5,
    ST_DESCEND  = 4'd6,
    ST_INC      = 4'd7,
    ST_UPDATE   = 4'd8,
    ST_CHECK    = 4'd9,
    ST_SORT_P   = 4'd10,
    ST_SORT_C   = 4'd11,
    ST_SORT_K   = 4'd12,
    ST_DONE     = 4'd13
  } state_e;

  // Level of heap-ordered node k: floor(log2(k+1)).
  function automatic logic [DEPTH_SIZE-1:0] heap_depth(input int unsigned k);
    int unsigned n;
    logic [DEPTH_SIZE-1:0] d;
    n = k + 1;
    d = '0;
    for (int unsigned i = 1; i < MAX_DEPTH; i++) begin
      if ((n >> i) != 0) d = DEPTH_SIZE'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/cluster_pe_sequencer.sv
// Command sequencer for the cluster PE tree: seeds centres, streams points,
// and iterates update/sort passes until the tree is stable or the cap is hit.
module cluster_pe_sequencer
  import cluster_pkg::*;
#(
  parameter int unsigned K_CENTERS  = 7,
  parameter int unsigned TREE_DEPTH = 3,
  parameter int unsigned NPTS_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [NPTS_W-1:0]      num_points,
  input  logic [7:0]             max_iter,
  input  logic                   pt_valid,
  input  logic [CENTER_SIZE-1:0] pt_data,
  output logic                   pt_ready,
  input  logic                   all_stable,
  input  logic                   any_switch,
  output logic                   init,
  output logic                   start_iter,
  output logic                   receive_point,
  output logic                   next_level,
  output logic                   inc,
  output logic                   update,
  output logic                   sorting,
  output logic                   parent_switch,
  output logic                   child_switch,
  output logic [CENTER_SIZE-1:0] point_out,
  output logic [CENTER_SIZE-1:0] seed_center,
  output logic [DEPTH_SIZE-1:0]  seed_depth,
  output logic [K_CENTERS-1:0]   pe_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic [7:0]             iter_count
);

  localparam int unsigned K_W      = $clog2(K_CENTERS + 1);
  localparam int unsigned LVL_W    = $clog2(TREE_DEPTH + 1);
  localparam int unsigned PASS_MAX = 2 * TREE_DEPTH;
  localparam int unsigned PASS_W   = $clog2(PASS_MAX + 1);

  state_e              state, state_nxt;
  logic [K_W-1:0]      k_cnt;
  logic [NPTS_W-1:0]   pt_cnt;
  logic [NPTS_W-1:0]   npts_q;
  logic [LVL_W-1:0]    lvl_cnt;
  logic [PASS_W-1:0]   pass_cnt;
  logic                sw_flag;
  logic [7:0]          max_iter_q;

  logic                last_seed_c;
  logic                last_level_c;
  logic                last_point_c;
  logic                iter_cap_c;
  logic                finish_c;
  logic                sort_exit_c;
  logic [7:0]          max_eff_c;

  assign last_seed_c  = (k_cnt == K_W'(K_CENTERS - 1));
  assign last_level_c = (lvl_cnt == LVL_W'(TREE_DEPTH - 1));
  assign last_point_c = ((NPTS_W+1)'(pt_cnt) + (NPTS_W+1)'(1)) == (NPTS_W+1)'(npts_q);
  assign max_eff_c    = (max_iter_q == 8'd0) ? 8'd1 : max_iter_q;
  assign iter_cap_c   = (9'(iter_count) + 9'd1) >= 9'(max_eff_c);
  assign finish_c     = all_stable || iter_cap_c;
  // A pass with no switch anywhere in its three cycles means the heap is sorted.
  assign sort_exit_c  = !(sw_flag || any_switch) || (pass_cnt == PASS_W'(PASS_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else if (en) state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pt_ready      = 1'b0;
    init          = 1'b0;
    start_iter    = 1'b0;
    receive_point = 1'b0;
    next_level    = 1'b0;
    inc           = 1'b0;
    update        = 1'b0;
    sorting       = 1'b0;
    parent_switch = 1'b0;
    child_switch  = 1'b0;
    done          = 1'b0;
    busy          = (state != ST_IDLE) && (state != ST_DONE);
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_SEED_RDY;
      ST_SEED_RDY: begin
        pt_ready = 1'b1;
        if (pt_valid) state_nxt = ST_SEED;
      end
      ST_SEED: begin
        init      = 1'b1;
        state_nxt = last_seed_c ? ST_START : ST_SEED_RDY;
      end
      ST_START: begin
        start_iter = 1'b1;
        state_nxt  = (npts_q == '0) ? ST_UPDATE : ST_RDY;
      end
      ST_RDY: begin
        pt_ready = 1'b1;
        if (pt_valid) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        receive_point = 1'b1;
        state_nxt     = ST_DESCEND;
      end
      ST_DESCEND: begin
        next_level = 1'b1;
        if (last_level_c) state_nxt = ST_INC;
      end
      ST_INC: begin
        inc       = 1'b1;
        state_nxt = last_point_c ? ST_UPDATE : ST_RDY;
      end
      ST_UPDATE: begin
        update    = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK:    state_nxt = finish_c ? ST_DONE : ST_SORT_P;
      ST_SORT_P: begin
        sorting       = 1'b1;
        parent_switch = 1'b1;
        state_nxt     = ST_SORT_C;
      end
      ST_SORT_C: begin
        sorting      = 1'b1;
        child_switch = 1'b1;
        state_nxt    = ST_SORT_K;
      end
      ST_SORT_K: begin
        sorting   = 1'b1;
        state_nxt = sort_exit_c ? ST_START : ST_SORT_P;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
    // Stall: nothing advances, so no command may be issued.
    if (!en) begin
      pt_ready      = 1'b0;
      init          = 1'b0;
      start_iter    = 1'b0;
      receive_point = 1'b0;
      next_level    = 1'b0;
      inc           = 1'b0;
      update        = 1'b0;
      sorting       = 1'b0;
      parent_switch = 1'b0;
      child_switch  = 1'b0;
      done          = 1'b0;
    end
  end

  // Counters, captured payloads and run results.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_cnt       <= '0;
      pt_cnt      <= '0;
      npts_q      <= '0;
      lvl_cnt     <= '0;
      pass_cnt    <= '0;
      sw_flag     <= 1'b0;
      max_iter_q  <= '0;
      point_out   <= '0;
      seed_center <= '0;
      seed_depth  <= '0;
      pe_sel      <= '0;
      converged   <= 1'b0;
      iter_count  <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: if (start) begin
          npts_q     <= num_points;
          max_iter_q <= max_iter;
          k_cnt      <= '0;
          iter_count <= '0;
          converged  <= 1'b0;
        end
        ST_SEED_RDY: if (pt_valid) begin
          seed_center <= pt_data;
          pe_sel      <= K_CENTERS'(1) << k_cnt;
          seed_depth  <= heap_depth(32'(k_cnt));
        end
        ST_SEED:    k_cnt <= k_cnt + K_W'(1);
        ST_START:   pt_cnt <= '0;
        ST_RDY:     if (pt_valid) point_out <= pt_data;
        ST_RECV:    lvl_cnt <= '0;
        ST_DESCEND: if (!last_level_c) lvl_cnt <= lvl_cnt + LVL_W'(1);
        ST_INC:     if (!last_point_c) pt_cnt <= pt_cnt + NPTS_W'(1);
        ST_CHECK: begin
          if (iter_count != 8'hFF) iter_count <= iter_count + 8'd1;
          if (finish_c) converged <= all_stable;
          pass_cnt <= '0;
          sw_flag  <= 1'b0;
        end
        ST_SORT_P, ST_SORT_C: sw_flag <= sw_flag | any_switch;
        ST_SORT_K: if (!sort_exit_c) begin
          pass_cnt <= pass_cnt + PASS_W'(1);
          sw_flag  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
